lcd_hd44780_ctrl: RTL and testbench

Hardware sequencer for the DE2 16x2 HD44780 character LCD. It replaces software bit-banging of the LCD PIO pins by the Nios system. The block runs the power-up init sequence on its own, then accepts byte writes (command or data) over a valid/ready handshake. It generates RS/EN/DATA timing and the required execution delays. It sits between the Nios-side PIO/register logic and the LCD pins at top level.

---
 rtl/lcd_hd44780_ctrl_if.sv | 10 +
 rtl/lcd_hd44780_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte-write handshake between the Nios-side requester and the HD44780 sequencer.
interface lcd_hd44780_ctrl_if;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 LCD sequencer: power-up init list, then command/data byte writes with EN timing.
// Define LCD_AUTOWRAP_EN to track the cursor and insert a line-change command after column 15.
module lcd_hd44780_ctrl #(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 4,
    parameter int EN_CYC      = 25,
    parameter int HOLD_CYC    = 4,
    parameter int EXEC_SHORT  = 2000,
    parameter int EXEC_LONG   = 82000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    lcd_hd44780_ctrl_if.slave cmd,
    output logic              init_done_o,
    input  logic              bl_en_i,
    output logic              lcd_on_o,
    output logic              lcd_blon_o,
    output logic              lcd_en_o,
    output logic              lcd_rw_o,
    output logic              lcd_rs_o,
    output logic [7:0]        lcd_data_o
);

    // state     | meaning
    // PWRUP     | post-reset power-on wait (counts up from the cleared counter)
    // INIT_LOAD | fetch next init byte
    // SETUP     | RS/DATA settle, EN low
    // ENH       | EN strobe high
    // HOLD      | EN low, RS/DATA held
    // EXEC      | LCD execution delay
    // IDLE      | waiting for a requester byte
    typedef enum logic [2:0] {
        PWRUP, INIT_LOAD, SETUP, ENH, HOLD, EXEC, IDLE
    } state_t;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(EXEC_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(EXEC_LONG - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             on_q, blon_q;

    logic             load;
    logic             ld_rs;
    logic [7:0]       ld_data;
    logic             wrap_go;
    logic [7:0]       wrap_byte;
    logic             tc;
    logic             exec_long;

    function automatic logic [7:0] init_byte(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    assign tc        = (cnt_q == '0);
    assign exec_long = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        load    = 1'b0;
        ld_rs   = 1'b0;
        ld_data = init_byte(idx_q);

        case (state_q)
            PWRUP: begin
                if (cnt_q == PWR_LAST) state_d = INIT_LOAD;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            INIT_LOAD: begin
                load    = 1'b1;
                state_d = SETUP;
            end
            SETUP: begin
                if (tc) state_d = ENH;
                else    cnt_d   = cnt_q - CNT_W'(1);
            end
            ENH: begin
                if (tc) state_d = HOLD;
                else    cnt_d   = cnt_q - CNT_W'(1);
            end
            HOLD: begin
                if (tc) state_d = EXEC;
                else    cnt_d   = cnt_q - CNT_W'(1);
            end
            EXEC: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!done_q) begin
                    if (idx_q == 3'd5) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = INIT_LOAD;
                    end
                end else if (wrap_go) begin
                    // Line-change command goes straight out, keeping the requester stalled.
                    load    = 1'b1;
                    ld_data = wrap_byte;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ready_q && cmd.cmd_valid) begin
                    load    = 1'b1;
                    ld_rs   = cmd.cmd_rs;
                    ld_data = cmd.cmd_data;
                    state_d = SETUP;
                end
            end
            default: state_d = PWRUP;
        endcase

        rs_d   = load ? ld_rs : rs_q;
        data_d = load ? ld_data : data_q;

        if (state_d != state_q) begin
            case (state_d)
                SETUP:   cnt_d = SETUP_LD;
                ENH:     cnt_d = EN_LD;
                HOLD:    cnt_d = HOLD_LD;
                EXEC:    cnt_d = exec_long ? LONG_LD : SHORT_LD;
                default: cnt_d = '0;
            endcase
        end

        en_d    = (state_d == ENH);
        ready_d = (state_d == IDLE) && done_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            on_q    <= 1'b0;
            blon_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            on_q    <= 1'b1;
            blon_q  <= bl_en_i;
        end
    end

`ifdef LCD_AUTOWRAP_EN
    logic       line_q, line_d;
    logic [3:0] col_q, col_d;
    logic       wrap_q, wrap_d;

    // Cursor follows every byte as it is loaded, init bytes included.
    always_comb begin
        line_d = line_q;
        col_d  = col_q;
        wrap_d = wrap_q;
        if (load) begin
            wrap_d = ld_rs && (col_q == 4'hF);
            if (ld_rs) begin
                col_d = col_q + 4'd1;
            end else if (ld_data[7]) begin
                line_d = ld_data[6];
                col_d  = ld_data[3:0];
            end else if (ld_data[7:2] == 6'd0 && ld_data[1:0] != 2'd0) begin
                line_d = 1'b0;
                col_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= 1'b0;
            col_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            line_q <= line_d;
            col_q  <= col_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap_go   = wrap_q;
    assign wrap_byte = line_q ? 8'h80 : 8'hC0;
`else
    assign wrap_go   = 1'b0;
    assign wrap_byte = 8'h80;
`endif

    assign cmd.cmd_ready = ready_q;
    assign init_done_o   = done_q;
    assign lcd_on_o      = on_q;
    assign lcd_blon_o    = blon_q;
    assign lcd_en_o      = en_q;
    assign lcd_rw_o      = 1'b0;
    assign lcd_rs_o      = rs_q;
    assign lcd_data_o    = data_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: transfer-timeline reference model checked every cycle, plus literal timing/byte checks.
module tb_lcd_hd44780_ctrl;
    localparam int P  = 100;
    localparam int S  = 2;
    localparam int E  = 4;
    localparam int H  = 2;
    localparam int XS = 20;
    localparam int XL = 50;
`ifdef LCD_AUTOWRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bl_en = 1'b0;
    logic       init_done, lcd_on, lcd_blon, lcd_en, lcd_rw, lcd_rs;
    logic [7:0] lcd_data;

    lcd_hd44780_ctrl_if bus();

    lcd_hd44780_ctrl #(
        .POWERUP_CYC(P), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .EXEC_SHORT(XS), .EXEC_LONG(XL), .CNT_W(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd(bus), .init_done_o(init_done),
        .bl_en_i(bl_en), .lcd_on_o(lcd_on), .lcd_blon_o(lcd_blon), .lcd_en_o(lcd_en),
        .lcd_rw_o(lcd_rw), .lcd_rs_o(lcd_rs), .lcd_data_o(lcd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    // Write log: one entry {rs,data} per EN rising edge.
    logic [8:0] wlog[$];
    int         en_hi = 0;
    logic       prev_en = 1'b0;
    always @(negedge clk) begin
        if (lcd_en && !prev_en) wlog.push_back({lcd_rs, lcd_data});
        if (lcd_en) en_hi <= en_hi + 1;
        prev_en <= lcd_en;
    end

    function automatic logic [7:0] init_b(input int k);
        case (k)
            0, 1, 2: return 8'h38;
            3:       return 8'h0C;
            4:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [8:0] log_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 9'h1FF;
    endfunction

    // Reference model: a transfer is a window of t = 0..len-1 cycles after the loading edge.
    typedef struct packed {
        logic       busy;
        int         t;
        int         len;
        logic       rs;
        logic [7:0] d;
        int         k;
        int         gap;
        logic       done;
        logic       wrap;
        logic       line;
        int         col;
        logic       on;
        logic       blon;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t start_xfer(input mdl_t s, input logic rs, input logic [7:0] d);
        mdl_t n;
        n      = s;
        n.busy = 1'b1;
        n.t    = 0;
        n.rs   = rs;
        n.d    = d;
        n.len  = S + E + H + ((!rs && d >= 8'h01 && d <= 8'h03) ? XL : XS);
        n.wrap = rs && (n.col == 15);
        if (rs) begin
            n.col = (n.col + 1) % 16;
        end else if (d >= 8'h80) begin
            n.line = d[6];
            n.col  = int'(d[3:0]);
        end else if (d >= 8'h01 && d <= 8'h03) begin
            n.line = 1'b0;
            n.col  = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        mdl_t n;
        if (!reset_n) begin
            n     = '0;
            n.gap = P + 1;
        end else begin
            n      = m;
            n.on   = 1'b1;
            n.blon = bl_en;
            if (n.busy) begin
                n.t = n.t + 1;
                if (n.t == n.len) begin
                    n.busy = 1'b0;
                    if (!n.done) begin
                        if (n.k == 5) n.done = 1'b1;
                        else begin
                            n.k   = n.k + 1;
                            n.gap = 1;
                        end
                    end else if (WRAP && n.wrap) begin
                        n = start_xfer(n, 1'b0, n.line ? 8'h80 : 8'hC0);
                    end
                end
            end else if (!n.done) begin
                n.gap = n.gap - 1;
                if (n.gap == 0) n = start_xfer(n, 1'b0, init_b(n.k));
            end else if (bus.cmd_valid) begin
                n = start_xfer(n, bus.cmd_rs, bus.cmd_data);
            end
        end
        m <= n;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        logic [14:0] ev, av;
        logic        een;
        @(negedge clk);
        een = m.busy && (m.t >= S) && (m.t < S + E);
        ev  = {m.on, m.blon, 1'b0, een, m.rs, m.d, m.done && !m.busy, m.done};
        av  = {lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs, lcd_data, bus.cmd_ready, init_done};
        total++;
        if (av !== ev) begin
            bad++;
            $display("FAIL outputs at edge %0d: got %h expected %h {on,blon,rw,en,rs,data,ready,done}", edge_n, av, ev);
        end
        bl_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 400; i++) begin
            if (bus.cmd_ready) return;
            tick();
        end
        check("ready_timeout", int'(bus.cmd_ready), 1);
    endtask

    task automatic wait_init(output int e);
        e = -1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (init_done) begin
                e = edge_n;
                return;
            end
        end
        check("init_timeout", int'(init_done), 1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int lat);
        int a;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = rs;
        bus.cmd_data  = d;
        tick();
        a = edge_n;
        bus.cmd_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.cmd_ready) begin
                lat = edge_n - a;
                break;
            end
        end
        if (lat < 0) check("send_timeout", int'(bus.cmd_ready), 1);
    endtask

    task automatic check_init_log(input int mk, input int enm);
        check("init_pulse_count", wlog.size() - mk, 6);
        for (int k = 0; k < 6; k++) check("init_byte", int'(log_at(mk + k)), int'({1'b0, init_b(k)}));
        check("init_en_high_cycles", en_hi - enm, 24);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mk, enm, e, cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_rs    = 1'b0;
        bus.cmd_data  = 8'h00;
        repeat (3) tick();

        // A byte left pending through the whole init sequence.
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = 1'b1;
        bus.cmd_data  = 8'h42;
        mk  = wlog.size();
        enm = en_hi;
        reset_n = 1'b1;
        tick();
        check("lcd_on_first_edge", int'(lcd_on), 1);
        wait_init(e);
        check("init_done_edge", e, 304);
        check_init_log(mk, enm);
        tick();
        bus.cmd_valid = 1'b0;
        wait_ready();
        check("pending_byte_count", wlog.size() - mk, 7);
        check("pending_byte", int'(log_at(mk + 6)), 9'h142);

        // 0x41 accepted, 0x42 held valid through the busy transfer.
        mk = wlog.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = 1'b1;
        bus.cmd_data  = 8'h41;
        tick();
        e = edge_n;
        bus.cmd_data = 8'h42;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.cmd_ready) begin
                lat = edge_n - e;
                break;
            end
        end
        check("latency_data_41", lat, 28);
        tick();
        bus.cmd_valid = 1'b0;
        wait_ready();
        cnt = 0;
        for (int i = mk; i < wlog.size(); i++) if (wlog[i] == 9'h142) cnt++;
        check("busy_byte_written_once", cnt, 1);
        check("busy_first_byte", int'(log_at(mk)), 9'h141);
        check("busy_pulse_count", wlog.size() - mk, 2);

        send(1'b0, 8'h01, lat);
        check("latency_clear", lat, 58);
        send(1'b0, 8'h80, lat);
        check("latency_set_ddram", lat, 28);
        send(1'b0, 8'h02, lat);
        check("latency_home", lat, 58);

        for (int i = 0; i < 30; i++) begin
            logic       r;
            logic [7:0] d;
            repeat ($urandom_range(0, 3)) tick();
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            send(r, d, lat);
        end

        // Line wrap: 32 data bytes from home position.
        send(1'b0, 8'h01, lat);
        mk = wlog.size();
        for (int i = 0; i < 32; i++) send(1'b1, 8'($urandom_range(32, 126)), lat);
`ifdef LCD_AUTOWRAP_EN
        check("wrap_pulse_count", wlog.size() - mk, 34);
        check("wrap_to_line1", int'(log_at(mk + 16)), 9'h0C0);
        check("wrap_to_line0", int'(log_at(mk + 33)), 9'h080);
`else
        check("nowrap_pulse_count", wlog.size() - mk, 32);
        cnt = 0;
        for (int i = mk; i < wlog.size(); i++) if (!wlog[i][8]) cnt++;
        check("nowrap_command_count", cnt, 0);
`endif

        // Reset while EN is high.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = 1'b1;
        bus.cmd_data  = 8'h55;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !lcd_en; i++) tick();
        check("en_high_before_reset", int'(lcd_en), 1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_immediate", int'({lcd_en, lcd_on, init_done, bus.cmd_ready}), 0);
        tick();
        tick();
        mk  = wlog.size();
        enm = en_hi;
        reset_n = 1'b1;
        wait_init(e);
        check("reinit_done_edge", e, 304);
        check_init_log(mk, enm);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
